// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional baud-rate strobe generator for the UART datapath
//
// Produces single-cycle enables in the clk_in domain instead of derived clocks:
// an oversample tick, a transmitter bit tick, and a receiver mid-bit sample
// strobe that can be re-phased on a start edge. The divisor is
// div_int + div_frac/2^FRAC_W clocks per oversample tick and can be reloaded
// at run time through a load/acknowledge handshake that only takes effect on
// a bit boundary (or whenever the generator is disabled).
//
// Ports:
//   clk_in        system clock
//   rst           asynchronous, active-high reset
//   en            generator enable; 0 holds all counters at zero
//   cfg_ld        single-cycle request to load cfg_div_int/cfg_div_frac
//   cfg_div_int   requested integer divisor, legal 2..2^DIV_W-1
//   cfg_div_frac  requested fractional divisor
//   cfg_ack       pulse: the pending divisor has become active
//   cfg_err       pulse: the load request was rejected (cfg_div_int < 2)
//   rx_resync     receiver saw a start edge; restart the rx bit phase
//   ovs_tick      oversample strobe
//   tx_tick       one strobe per bit period
//   rx_sample     strobe at the bit centre

module uart_baud_gen_frac #(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OVS          = 16,
    parameter int unsigned RST_DIV_INT  = 325,
    parameter int unsigned RST_DIV_FRAC = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_ld,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              cfg_ack,
    output logic              cfg_err,
    input  logic              rx_resync,
    output logic              ovs_tick,
    output logic              tx_tick,
    output logic              rx_sample
);

    localparam int unsigned PH_W = $clog2(OVS);

    // Active divisor and the shadow copy waiting for a bit boundary
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [DIV_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic              pending;

    // cnt is one bit wider than the divisor so a period of div_int + 1
    // (carry set with div_int at its maximum) is still representable.
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              c;
    logic [PH_W-1:0]   txp;
    logic [PH_W-1:0]   rxp;

    logic [DIV_W:0]    period;
    logic              fire;
    logic              apply;
    logic              ld_ok;
    logic              ld_bad;
    logic [FRAC_W:0]   acc_sum;

    always_comb begin
        period  = {1'b0, div_int} + {{DIV_W{1'b0}}, c};
        // cnt holds the number of enabled edges seen in the current period,
        // so the tick lands exactly `period` edges after the period started.
        fire    = en && (cnt == period);
        // tx_tick is registered, so the cycle it is high is the bit boundary
        apply   = pending && (!en || tx_tick);
        ld_ok   = cfg_ld && (cfg_div_int >= DIV_W'(2));
        ld_bad  = cfg_ld && (cfg_div_int <  DIV_W'(2));
        acc_sum = {1'b0, acc} + {1'b0, div_frac};
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_int   <= DIV_W'(RST_DIV_INT);
            div_frac  <= FRAC_W'(RST_DIV_FRAC);
            shd_int   <= DIV_W'(RST_DIV_INT);
            shd_frac  <= FRAC_W'(RST_DIV_FRAC);
            pending   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            c         <= 1'b0;
            txp       <= '0;
            rxp       <= '0;
            ovs_tick  <= 1'b0;
            tx_tick   <= 1'b0;
            rx_sample <= 1'b0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ack <= apply;
            cfg_err <= ld_bad;

            if (apply) begin
                // Restart all timing from a clean bit boundary with the new rate
                div_int   <= shd_int;
                div_frac  <= shd_frac;
                cnt       <= '0;
                acc       <= '0;
                c         <= 1'b0;
                txp       <= '0;
                rxp       <= '0;
                ovs_tick  <= 1'b0;
                tx_tick   <= 1'b0;
                rx_sample <= 1'b0;
            end else if (!en) begin
                cnt       <= '0;
                acc       <= '0;
                c         <= 1'b0;
                txp       <= '0;
                rxp       <= '0;
                ovs_tick  <= 1'b0;
                tx_tick   <= 1'b0;
                rx_sample <= 1'b0;
            end else begin
                ovs_tick  <= fire;
                tx_tick   <= fire && (txp == PH_W'(OVS - 1));
                // A resync on a tick edge starts a new bit, so that tick is not a centre
                rx_sample <= fire && !rx_resync && (rxp == PH_W'(OVS / 2 - 1));

                if (fire) begin
                    // The tick edge itself counts as the first edge of the next period
                    cnt      <= {{DIV_W{1'b0}}, 1'b1};
                    {c, acc} <= acc_sum;
                    txp      <= txp + PH_W'(1);
                end else begin
                    cnt <= cnt + {{DIV_W{1'b0}}, 1'b1};
                end

                if (rx_resync) begin
                    rxp <= '0;
                end else if (fire) begin
                    rxp <= rxp + PH_W'(1);
                end
            end

            // A load coincident with apply lands in the shadow after the old
            // shadow has been consumed, so it stays pending for the next boundary.
            if (ld_ok) begin
                shd_int  <= cfg_div_int;
                shd_frac <= cfg_div_frac;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - self-checking bench for uart_baud_gen_frac

module tb_uart_baud_gen_frac;

    localparam int OVS   = 16;
    localparam int FSCL  = 16;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_ld;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        cfg_ack;
    logic        cfg_err;
    logic        rx_resync;
    logic        ovs_tick;
    logic        tx_tick;
    logic        rx_sample;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    int exp_t [0:63];
    int ovs_q[$];
    int tx_q[$];
    int ack_q[$];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    uart_baud_gen_frac dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .cfg_ld       (cfg_ld),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .rx_resync    (rx_resync),
        .ovs_tick     (ovs_tick),
        .tx_tick      (tx_tick),
        .rx_sample    (rx_sample)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_ovs"}, ovs_tick, 1'b0);
        chk1({tag, "_tx"}, tx_tick, 1'b0);
        chk1({tag, "_rx"}, rx_sample, 1'b0);
        chk1({tag, "_ack"}, cfg_ack, 1'b0);
        chk1({tag, "_err"}, cfg_err, 1'b0);
    endtask

    task automatic step();
        @(negedge clk_in);
        if (ovs_tick) ovs_q.push_back(cyc);
        if (tx_tick)  tx_q.push_back(cyc);
        if (cfg_ack)  ack_q.push_back(cyc);
    endtask

    task automatic load(input int di, input int df);
        cfg_ld       = 1'b1;
        cfg_div_int  = 16'(di);
        cfg_div_frac = 4'(df);
        step();
        cfg_ld       = 1'b0;
    endtask

    // Called at a negedge right after en is raised. Expected tick times come
    // from the mean-rate rule: each period is div + carry of the running
    // fractional sum. Checks every output on every cycle up to the n-th tick;
    // optionally pulses rx_resync so it is sampled on tick rs_k.
    task automatic check_ticks(input int div, input int frac, input int n, input int rs_k);
        int e0, t, a, s, k;
        logic is_t, exp_tx, exp_rx;
        e0 = cyc + 1;
        t  = e0 + div;
        a  = 0;
        for (int i = 1; i <= n; i++) begin
            exp_t[i] = t;
            s = a + frac;
            a = s % FSCL;
            t = t + div + s / FSCL;
        end
        k = 1;
        while (cyc < exp_t[n]) begin
            rx_resync = (rs_k > 0 && cyc == exp_t[rs_k] - 1);
            @(negedge clk_in);
            is_t   = (k <= n) && (cyc == exp_t[k]);
            exp_tx = is_t && (k % OVS == 0);
            if (rs_k > 0 && k > rs_k)
                exp_rx = is_t && ((k - rs_k) % OVS == OVS / 2);
            else
                exp_rx = is_t && (k % OVS == OVS / 2);
            chk1("ovs_tick", ovs_tick, is_t);
            chk1("tx_tick", tx_tick, exp_tx);
            chk1("rx_sample", rx_sample, exp_rx);
            chk1("run_ack", cfg_ack, 1'b0);
            chk1("run_err", cfg_err, 1'b0);
            if (is_t) k++;
        end
        rx_resync = 1'b0;
    endtask

    initial begin
        int e0, di, df, rs, ack_t;
        int post[$];

        rst = 1'b1; en = 1'b0; cfg_ld = 1'b0; rx_resync = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0;
        repeat (3) @(negedge clk_in);
        chk_quiet("reset");
        rst = 1'b0;

        // Disabled generator stays silent, then the reset rate runs
        for (int i = 0; i < 100; i++) begin
            step();
            chk_quiet("idle");
        end
        en = 1'b1;
        check_ticks(325, 8, 3, 0);

        // Load 4 + 8/16 while disabled
        en = 1'b0;
        load(4, 8);
        step(); chk1("ld4_ack", cfg_ack, 1'b1);
        step(); chk1("ld4_ack_width", cfg_ack, 1'b0);
        en = 1'b1;
        check_ticks(4, 8, 34, 0);

        // Illegal divisors are rejected and the rate is unchanged
        en = 1'b0;
        load(1, 5);
        chk1("ld1_err", cfg_err, 1'b1); chk1("ld1_noack", cfg_ack, 1'b0);
        step(); chk1("ld1_err_width", cfg_err, 1'b0); chk1("ld1_noack2", cfg_ack, 1'b0);
        load(0, 3);
        chk1("ld0_err", cfg_err, 1'b1); chk1("ld0_noack", cfg_ack, 1'b0);
        step(); chk1("ld0_err_width", cfg_err, 1'b0); chk1("ld0_noack2", cfg_ack, 1'b0);
        step(); chk1("ld0_noack3", cfg_ack, 1'b0);
        en = 1'b1;
        check_ticks(4, 8, 20, 0);

        // Load coincident with an apply point: older shadow first, then the new one
        en = 1'b0;
        load(6, 3);
        load(9, 2);
        chk1("coin_ack1", cfg_ack, 1'b1);
        step(); chk1("coin_ack2", cfg_ack, 1'b1);
        step(); chk1("coin_ack_end", cfg_ack, 1'b0);
        en = 1'b1;
        check_ticks(9, 2, 20, 0);

        // Randomised divisors, every other run with a receiver resync
        for (int it = 0; it < 4; it++) begin
            di = int'($urandom_range(2, 24));
            df = int'($urandom_range(0, 15));
            rs = (it % 2 == 1) ? int'($urandom_range(10, 14)) : 0;
            en = 1'b0;
            load(di, df);
            step(); chk1("rnd_ack", cfg_ack, 1'b1);
            step(); chk1("rnd_ack_width", cfg_ack, 1'b0);
            en = 1'b1;
            check_ticks(di, df, 34, rs);
        end

        // Two loads in one bit while running: last wins, single ack after tx_tick
        en = 1'b0;
        load(10, 0);
        step(); chk1("s5_ack0", cfg_ack, 1'b1);
        step();
        en = 1'b1;
        e0 = cyc + 1;
        ovs_q.delete(); tx_q.delete(); ack_q.delete();
        while (cyc < e0 + 50) step();
        load(20, 0);
        while (cyc < e0 + 100) step();
        load(30, 0);
        while (cyc < e0 + 700) step();
        for (int k = 1; k <= 16; k++) chkn("s5_pre_tick", ovs_q[k - 1], e0 + 10 * k);
        chkn("s5_tx_time", tx_q[0], e0 + 160);
        chkn("s5_ack_count", ack_q.size(), 1);
        chkn("s5_ack_time", ack_q[0], e0 + 161);
        ack_t = ack_q[0];
        post.delete();
        foreach (ovs_q[i]) if (ovs_q[i] > ack_t) post.push_back(ovs_q[i]);
        chkn("s5_post_count_ok", int'(post.size() >= 17), 1);
        for (int i = 1; i < 16; i++) chkn("s5_period", post[i] - post[i - 1], 30);
        chkn("s5_tx_after_apply", tx_q[1], post[15]);

        // Resync with an integer divisor
        en = 1'b0;
        load(4, 0);
        step(); chk1("s6_ack", cfg_ack, 1'b1);
        step();
        en = 1'b1;
        check_ticks(4, 0, 40, int'($urandom_range(10, 14)));

        // Reset mid-period with a load pending
        load(7, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (ovs_tick) break;
        end
        chk1("s7_tick_before_rst", ovs_tick, 1'b1);
        #2 rst = 1'b1;
        #1 chk_quiet("s7_async_rst");
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b0;
        ovs_q.delete(); ack_q.delete();
        repeat (8) step();
        chkn("s7_no_ack", ack_q.size(), 0);
        chkn("s7_no_tick", ovs_q.size(), 0);
        en = 1'b1;
        check_ticks(325, 8, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Parametrised fractional baud-rate generator for the UART datapath. It replaces derived toggling clocks with single-cycle enable strobes in the `clk_in` domain:
- an oversample tick;
- a transmitter bit tick;
- a receiver mid-bit sample strobe that the receiver can re-phase on a start edge.

The divisor is programmable at run time with a fractional part. A load/acknowledge handshake applies a new rate only on a bit boundary.

## Interface
- DIV_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor; resolution is 1/2^FRAC_W clock.
- OVS, 16, oversample ticks per bit; power of two, at least 4.
- RST_DIV_INT, 325, integer divisor after reset (9600 baud x16 at 50 MHz).
- RST_DIV_FRAC, 8, fractional divisor after reset.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  generator enable.
- cfg_ld  in  1  single-cycle request to load a new divisor.
- cfg_div_int  in  DIV_W  requested integer divisor; legal range 2..2^DIV_W-1.
- cfg_div_frac  in  FRAC_W  requested fractional divisor.
- cfg_ack  out  1  one-cycle pulse: the pending divisor is now active.
- cfg_err  out  1  one-cycle pulse: the load was rejected.
- rx_resync  in  1  receiver detected a start edge; re-phase the sample strobe.
- ovs_tick  out  1  one-cycle oversample strobe.
- tx_tick  out  1  one-cycle strobe per bit period.
- rx_sample  out  1  one-cycle strobe at the bit centre.

## Operation

Active state:
- Registers div_int, div_frac, cycle counter cnt, fractional accumulator acc, carry c, tx phase txp, rx phase rxp.
- Pending flag plus a shadow divisor.

Oversample timing:
- Period length is div_int + c clocks. ovs_tick fires once per period.
- On each ovs_tick, {c, acc} <= acc + div_frac, computed FRAC_W+1 wide. Mean period is div_int + div_frac/2^FRAC_W.

Bit phase:
- txp increments modulo OVS on each ovs_tick. tx_tick = ovs_tick AND txp == OVS-1.
- rxp increments modulo OVS on each ovs_tick. rx_sample = ovs_tick AND rxp == OVS/2-1.
- rx_resync forces rxp to 0 that cycle, taking priority over increment. cnt, acc and txp are unaffected. rx_sample therefore fires on the (OVS/2)-th ovs_tick after resync.

Enable:
- en = 0: cnt, acc, c, txp and rxp are held at 0 and no strobes are produced. The pending configuration still applies on the next cycle.

Configuration:
- cfg_ld with cfg_div_int < 2 is rejected: cfg_err pulses the next cycle, and the shadow and pending flag are unchanged.
- A legal cfg_ld writes the shadow and sets pending.
- A second cfg_ld while pending overwrites the shadow; last wins, and only one ack is produced.
- Apply point is the tx_tick cycle, or any cycle with en = 0. At apply: the active divisor takes the shadow value; cnt, acc, c, txp and rxp restart at 0; pending clears; cfg_ack pulses the next cycle.
- A cfg_ld coincident with apply: the older shadow is applied, and the new request stays pending for the next apply point.

## Timing
- All outputs are registered. Reset values: ovs_tick, tx_tick, rx_sample, cfg_ack, cfg_err = 0; div_int = RST_DIV_INT, div_frac = RST_DIV_FRAC; all counters and pending = 0.
- First ovs_tick occurs exactly div_int clocks after the first edge at which en is sampled 1. Subsequent ovs_ticks are separated by div_int + c clocks.
- tx_tick and rx_sample coincide only with ovs_tick cycles and are never wider than one clock.
- cfg_ack and cfg_err have latency of exactly 1 clock after the apply or reject event.
- Asserting rst mid-bit immediately clears all strobes and discards any pending load. Operation resumes with the RST_ divisor.

## Test plan
- Reset with en = 0 -> all outputs 0 for 100 cycles. Then en = 1 -> first ovs_tick at 325 clocks, second 325 clocks later, third at +326.
- Load int = 4, frac = 8 with en = 0 -> cfg_ack 1 cycle later. Then en = 1 -> ovs periods 4, 4, 5, 4, 5, …; 16th ovs_tick and first tx_tick at 71 clocks.
- Load int = 1 -> cfg_err single pulse, no cfg_ack, rate unchanged. Load int = 0 -> same behaviour.
- While running int = 10, frac = 0, load int = 20 mid-bit, then again int = 30 before the bit ends -> one cfg_ack after the next tx_tick. Subsequent periods are 30 clocks.
- Running int = 4, frac = 0: pulse rx_resync -> rx_sample 32 clocks later (8 ovs ticks). tx_tick spacing stays 64 clocks.
- Assert rst mid-period while pending -> outputs 0 immediately. After release, the 325/8 timing resumes and no cfg_ack appears.
